// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload/download controller.
package nvram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_READY,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_RELEASE
  } nvram_state_t;

  localparam logic [15:0] NVRAM_INDEX_DEF  = 16'd4;
  localparam logic [3:0]  CMOS_FILL_NIBBLE = 4'hF;
  localparam logic [7:0]  OOR_BYTE         = 8'hFF;

endpackage

// File: rtl/nvram_upload_ctrl.sv
// Moves the Williams CMOS RAM between the core and the HPS over ioctl,
// halting the 6809 while this block owns the CMOS port.
//
// state      | meaning
// IDLE       | no session, CPU runs, port released
// HOLD       | cpu_hold asserted, waiting for ack or timeout
// READY      | port owned, waiting for (or servicing a latched) strobe
// RD_ADDR    | CMOS address presented for a read
// RD_DATA    | CMOS data valid, ioctl_din loaded
// WR         | cmos_we pulse
// RELEASE    | port dropped, then cpu_hold dropped, then IDLE
module nvram_upload_ctrl
  import nvram_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter logic [15:0] NVRAM_INDEX  = NVRAM_INDEX_DEF,
  parameter int          HOLD_TIMEOUT = 64
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cpu_hold,
  input  logic              cpu_hold_ack,
  output logic              cmos_sel,
  output logic [ADDR_W-1:0] cmos_addr,
  output logic              cmos_we,
  output logic [3:0]        cmos_wdata,
  input  logic [3:0]        cmos_rdata,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  nvram_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_wr_q, pend_wr_d;
  logic [24:0]       pend_addr_q, pend_addr_d;
  logic [3:0]        pend_data_q, pend_data_d;
  logic              rel_q, rel_d;
  logic              oor_q, oor_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              hold_q, hold_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wdata_q, wdata_d;

  logic        session, wr_acc, rd_acc;
  logic        acc_go, acc_wr, acc_oor;
  logic [24:0] acc_addr;
  logic [3:0]  acc_data;
  logic        unused_dout_hi;

  // A download session takes precedence, so a coincident rd is dropped.
  assign session = (ioctl_upload | ioctl_download) && (ioctl_index == NVRAM_INDEX);
  assign wr_acc  = session && ioctl_download && ioctl_wr;
  assign rd_acc  = session && !ioctl_download && ioctl_rd;

  assign acc_go   = pend_v_q | wr_acc | rd_acc;
  assign acc_wr   = pend_v_q ? pend_wr_q   : wr_acc;
  assign acc_addr = pend_v_q ? pend_addr_q : ioctl_addr;
  assign acc_data = pend_v_q ? pend_data_q : ioctl_dout[3:0];
  assign acc_oor  = |acc_addr[24:ADDR_W];

  assign unused_dout_hi = ^ioctl_dout[7:4];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_v_d    = pend_v_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    rel_d       = rel_q;
    oor_d       = oor_q;
    din_d       = din_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    sel_d       = sel_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (session) begin
          state_d  = ST_HOLD;
          hold_d   = 1'b1;
          cnt_d    = '0;
          wait_d   = 1'b1;
          pend_v_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (wr_acc || rd_acc) begin
          pend_v_d    = 1'b1;
          pend_wr_d   = wr_acc;
          pend_addr_d = ioctl_addr;
          pend_data_d = ioctl_dout[3:0];
        end
        if (cpu_hold_ack || cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          sel_d   = 1'b1;
          wait_d  = pend_v_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (acc_go) begin
          pend_v_d = 1'b0;
          addr_d   = acc_addr[ADDR_W-1:0];
          oor_d    = acc_oor;
          wait_d   = 1'b1;
          if (acc_wr) begin
            state_d = ST_WR;
            wdata_d = acc_data;
            we_d    = !acc_oor;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        din_d   = oor_q ? OOR_BYTE : {CMOS_FILL_NIBBLE, cmos_rdata};
        wait_d  = 1'b0;
        state_d = ST_READY;
      end
      ST_WR: begin
        wait_d  = 1'b0;
        state_d = ST_READY;
      end
      ST_RELEASE: begin
        if (!rel_q) begin
          hold_d = 1'b0;
          rel_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Session loss overrides everything; no write may start as the port drops.
    if (state_q != ST_IDLE && state_q != ST_RELEASE && !session) begin
      state_d  = ST_RELEASE;
      sel_d    = 1'b0;
      we_d     = 1'b0;
      wait_d   = 1'b0;
      rel_d    = 1'b0;
      pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rel_q       <= 1'b0;
      oor_q       <= 1'b0;
      din_q       <= 8'h00;
      wait_q      <= 1'b0;
      hold_q      <= 1'b0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rel_q       <= rel_d;
      oor_q       <= oor_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign cpu_hold   = hold_q;
  assign cmos_sel   = sel_q;
  assign cmos_we    = we_q;
  assign cmos_addr  = addr_q;
  assign cmos_wdata = wdata_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Directed bench for nvram_upload_ctrl with a behavioural synchronous CMOS RAM.
module tb_nvram_upload_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0, ioctl_download = 1'b0;
  logic [15:0] ioctl_index = 16'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        ioctl_rd = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, cpu_hold, cmos_sel, cmos_we, busy;
  logic        cpu_hold_ack = 1'b0;
  logic [9:0]  cmos_addr;
  logic [3:0]  cmos_wdata;
  logic [3:0]  cmos_rdata = 4'd0;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  int viol = 0;

  logic [3:0] mem [0:1023];
  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = 10'd0;
  logic [3:0] pre_data = 4'd0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .cpu_hold(cpu_hold), .cpu_hold_ack(cpu_hold_ack),
    .cmos_sel(cmos_sel), .cmos_addr(cmos_addr), .cmos_we(cmos_we),
    .cmos_wdata(cmos_wdata), .cmos_rdata(cmos_rdata), .busy(busy)
  );

  always @(posedge clk_sys) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (cmos_we && cmos_sel) mem[cmos_addr] <= cmos_wdata;
    cmos_rdata <= mem[cmos_addr];
    if (cmos_we) we_count <= we_count + 1;
    if (cmos_we && !cmos_sel) viol <= viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [3:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic open_granted(input logic up, input logic dn);
    ioctl_index = 16'd4; ioctl_upload = up; ioctl_download = dn;
    tick();
    cpu_hold_ack = 1'b1;
    tick();
  endtask

  task automatic close_session();
    ioctl_upload = 1'b0; ioctl_download = 1'b0; cpu_hold_ack = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({ioctl_din, ioctl_wait, cpu_hold, cmos_sel, cmos_we, cmos_addr, cmos_wdata, busy} !== 27'd0) begin
      errors++;
      $display("FAIL reset_values: got din=%h wait=%b hold=%b sel=%b we=%b addr=%h wdata=%h busy=%b want all 0",
               ioctl_din, ioctl_wait, cpu_hold, cmos_sel, cmos_we, cmos_addr, cmos_wdata, busy);
    end
    reset_n = 1'b1;
    tick();
    preload(10'h005, 4'hA);
    preload(10'h000, 4'h3);
    preload(10'h010, 4'h0);
    preload(10'h020, 4'h0);
    preload(10'h3FF, 4'h0);
  endtask

  task automatic test_upload();
    ioctl_index = 16'd4; ioctl_upload = 1'b1;
    tick();
    checks++;
    if ({cpu_hold, busy, ioctl_wait} !== 3'b111) begin
      errors++; $display("FAIL upload_hold_entry: got hold/busy/wait=%b%b%b want 111", cpu_hold, busy, ioctl_wait);
    end
    repeat (3) tick();
    checks++;
    if (cmos_sel !== 1'b0) begin errors++; $display("FAIL upload_sel_before_ack: got %b want 0", cmos_sel); end
    cpu_hold_ack = 1'b1;
    tick();
    checks++;
    if ({cmos_sel, ioctl_wait} !== 2'b10) begin
      errors++; $display("FAIL upload_sel_after_ack: got sel/wait=%b%b want 10", cmos_sel, ioctl_wait);
    end
    ioctl_addr = 25'h005; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    checks++;
    if (cmos_addr !== 10'h005 || ioctl_wait !== 1'b1) begin
      errors++; $display("FAIL upload_n1: got addr=%h wait=%b want 005 1", cmos_addr, ioctl_wait);
    end
    tick();
    checks++;
    if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL upload_n2_wait: got %b want 1", ioctl_wait); end
    tick();
    checks++;
    if (ioctl_din !== 8'hFA || ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL upload_n3: got din=%h wait=%b want FA 0", ioctl_din, ioctl_wait);
    end
    close_session();
  endtask

  task automatic test_download();
    int base;
    open_granted(1'b0, 1'b1);
    base = we_count;
    ioctl_addr = 25'h3FF; ioctl_dout = 8'h37; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if (cmos_we !== 1'b1 || cmos_addr !== 10'h3FF || cmos_wdata !== 4'h7 || ioctl_wait !== 1'b1) begin
      errors++; $display("FAIL download_n1: got we=%b addr=%h wdata=%h wait=%b want 1 3FF 7 1",
                         cmos_we, cmos_addr, cmos_wdata, ioctl_wait);
    end
    tick();
    checks++;
    if (cmos_we !== 1'b0 || ioctl_wait !== 1'b0 || (we_count - base) !== 1) begin
      errors++; $display("FAIL download_n2: got we=%b wait=%b pulses=%0d want 0 0 1", cmos_we, ioctl_wait, we_count - base);
    end
    close_session();
    open_granted(1'b1, 1'b0);
    ioctl_addr = 25'h3FF; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    repeat (2) tick();
    checks++;
    if (ioctl_din !== 8'hF7) begin errors++; $display("FAIL download_readback: got %h want F7", ioctl_din); end
    close_session();
  endtask

  task automatic test_out_of_range();
    int base;
    open_granted(1'b1, 1'b0);
    ioctl_addr = 25'h400; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    repeat (2) tick();
    checks++;
    if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL oor_read: got din=%h wait=%b want FF 0", ioctl_din, ioctl_wait);
    end
    close_session();
    open_granted(1'b0, 1'b1);
    base = we_count;
    ioctl_addr = 25'h400; ioctl_dout = 8'h05; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if (cmos_we !== 1'b0 || ioctl_wait !== 1'b1) begin
      errors++; $display("FAIL oor_write_n1: got we=%b wait=%b want 0 1", cmos_we, ioctl_wait);
    end
    tick();
    checks++;
    if (ioctl_wait !== 1'b0 || we_count !== base) begin
      errors++; $display("FAIL oor_write_n2: got wait=%b pulses=%0d want 0 0", ioctl_wait, we_count - base);
    end
    close_session();
    checks++;
    if (mem[0] !== 4'h3) begin errors++; $display("FAIL oor_no_alias: got mem0=%h want 3", mem[0]); end
  endtask

  task automatic test_timeout();
    int k;
    ioctl_index = 16'd4; ioctl_upload = 1'b1; cpu_hold_ack = 1'b0;
    tick();
    k = 0;
    tick(); k++;
    ioctl_addr = 25'h005; ioctl_rd = 1'b1;
    tick(); k++;
    ioctl_rd = 1'b0;
    for (int i = 0; i < 100 && cmos_sel !== 1'b1; i++) begin
      tick(); k++;
    end
    checks++;
    if (k !== 64 || cmos_sel !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL timeout_sel: got cycles=%0d sel=%b hold=%b want 64 1 1", k, cmos_sel, cpu_hold);
    end
    checks++;
    if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL timeout_pending_wait: got %b want 1", ioctl_wait); end
    repeat (3) tick();
    checks++;
    if (ioctl_din !== 8'hFA || ioctl_wait !== 1'b0) begin
      errors++; $display("FAIL timeout_pending_read: got din=%h wait=%b want FA 0", ioctl_din, ioctl_wait);
    end
    close_session();
  endtask

  task automatic test_arbitration();
    open_granted(1'b1, 1'b1);
    ioctl_addr = 25'h020; ioctl_dout = 8'hA9; ioctl_rd = 1'b1; ioctl_wr = 1'b1;
    tick();
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    checks++;
    if (cmos_we !== 1'b1 || cmos_wdata !== 4'h9) begin
      errors++; $display("FAIL arb_write_wins: got we=%b wdata=%h want 1 9", cmos_we, cmos_wdata);
    end
    tick();
    close_session();
    checks++;
    if (mem[10'h020] !== 4'h9) begin errors++; $display("FAIL arb_mem: got %h want 9", mem[10'h020]); end
  endtask

  task automatic test_reset_mid_write();
    open_granted(1'b0, 1'b1);
    ioctl_addr = 25'h010; ioctl_dout = 8'h0C; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++;
    if (cmos_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b want 1", cmos_we); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cmos_we, cmos_sel, cpu_hold, ioctl_wait} !== 4'b0000) begin
      errors++; $display("FAIL rst_async: got we/sel/hold/wait=%b%b%b%b want 0000", cmos_we, cmos_sel, cpu_hold, ioctl_wait);
    end
    ioctl_download = 1'b0; cpu_hold_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || mem[10'h010] !== 4'h0) begin
      errors++; $display("FAIL rst_after: got busy=%b hold=%b mem=%h want 0 0 0", busy, cpu_hold, mem[10'h010]);
    end
  endtask

  task automatic test_session_end();
    open_granted(1'b1, 1'b0);
    ioctl_upload = 1'b0;
    tick();
    checks++;
    if ({cmos_sel, cpu_hold, busy} !== 3'b011) begin
      errors++; $display("FAIL end_c1: got sel/hold/busy=%b%b%b want 011", cmos_sel, cpu_hold, busy);
    end
    tick();
    checks++;
    if ({cmos_sel, cpu_hold, busy} !== 3'b001) begin
      errors++; $display("FAIL end_c2: got sel/hold/busy=%b%b%b want 001", cmos_sel, cpu_hold, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL end_c3: got busy=%b want 0", busy); end
    cpu_hold_ack = 1'b0;
  endtask

  task automatic test_wrong_index();
    ioctl_index = 16'd0; ioctl_upload = 1'b1;
    tick();
    ioctl_addr = 25'h005; ioctl_rd = 1'b1; ioctl_wr = 1'b1;
    tick();
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cpu_hold, busy, ioctl_wait, cmos_sel} !== 4'b0000) begin
      errors++; $display("FAIL wrong_index: got hold/busy/wait/sel=%b%b%b%b want 0000", cpu_hold, busy, ioctl_wait, cmos_sel);
    end
    ioctl_upload = 1'b0; ioctl_index = 16'd4;
  endtask

  initial begin
    test_reset();
    test_upload();
    test_download();
    test_out_of_range();
    test_timeout();
    test_arbitration();
    test_reset_mid_write();
    test_session_end();
    test_wrong_index();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL we_without_sel: got %0d want 0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvram_upload_ctrl.md
# nvram_upload_ctrl

Arbiter and transfer engine that moves the 1 K × 4-bit Williams CMOS (high-score/settings) RAM between the game core and the HPS over the ioctl channel.

- It answers HPS upload reads, so saved NVRAM can be written to SD.
- It accepts HPS downloads on the NVRAM index, so saved NVRAM is restored into the core.
- It sits between `hps_io` and the `williams2` CMOS RAM port, and halts the 6809 while it owns that port.

## Interface
Parameters:
- `ADDR_W`, 10: CMOS address width, 1024 nibbles.
- `NVRAM_INDEX`, 16'd4: ioctl_index value that selects NVRAM transfers.
- `HOLD_TIMEOUT`, 64: clk_sys cycles to wait for cpu_hold_ack before taking the port anyway.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_sys` in 1: system clock, 12 MHz.
  - `reset_n` in 1: asynchronous, active-low reset.
- HPS ioctl side:
  - `ioctl_upload` in 1: HPS upload (read-from-core) session active.
  - `ioctl_download` in 1: HPS download session active.
  - `ioctl_index` in 16: transfer index; only `NVRAM_INDEX` is serviced.
  - `ioctl_addr` in 25: byte address.
  - `ioctl_rd` in 1: one-cycle read strobe.
  - `ioctl_wr` in 1: one-cycle write strobe.
  - `ioctl_dout` in 8: write data.
  - `ioctl_din` out 8: read data.
  - `ioctl_wait` out 1: HPS must not issue the next strobe while high.
- CPU hold handshake:
  - `cpu_hold` out 1: request to halt the CPU.
  - `cpu_hold_ack` in 1: CPU halted.
- CMOS RAM port:
  - `cmos_sel` out 1: 1 = this block drives the CMOS port.
  - `cmos_addr` out ADDR_W.
  - `cmos_we` out 1.
  - `cmos_wdata` out 4.
  - `cmos_rdata` in 4: synchronous RAM, data valid the cycle after the address.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Session is defined as (`ioctl_upload` | `ioctl_download`) & (`ioctl_index` == `NVRAM_INDEX`). Strobes outside a session are ignored.
- FSM states: IDLE, HOLD, READY, RD_ADDR, RD_DATA, WR, RELEASE.
  - IDLE → HOLD on session start. `cpu_hold` goes high and the timeout counter clears.
  - HOLD → READY on `cpu_hold_ack`, or when the counter reaches `HOLD_TIMEOUT`-1. `cmos_sel` goes high on entry to READY.
  - READY → RD_ADDR on `ioctl_rd` during an upload.
  - READY → WR on `ioctl_wr` during a download.
  - RD_ADDR → RD_DATA; RD_DATA → READY. `ioctl_din` is loaded in RD_DATA.
  - WR → READY.
  - Any state (except IDLE and RELEASE) → RELEASE when the session ends. RELEASE drops `cmos_sel`, then drops `cpu_hold` one cycle later, then → IDLE.
- Data mapping:
  - Upload byte = {4'hF, nibble}. Unused Williams CMOS bits read back as 1.
  - Download writes `ioctl_dout[3:0]`; the upper nibble is discarded.
  - Byte address maps 1:1 to the CMOS address.
- Out-of-range addresses (`ioctl_addr` ≥ 2^ADDR_W):
  - Reads return 8'hFF.
  - Writes suppress `cmos_we`.
  - Handshake timing is unchanged.
- Strobe arbitration and buffering:
  - `ioctl_rd` and `ioctl_wr` in the same cycle: download session wins (write). If both upload and download are active, treat the session as download.
  - Strobes arriving in HOLD are latched (one entry, address and data) and serviced on entry to READY. A second strobe while one is pending is a protocol violation; it overwrites the pending entry.
- `ioctl_wait` is high in HOLD, and from a strobe until the access completes.

## Timing
- Reset values: `ioctl_din`=8'h00, `ioctl_wait`=0, `cpu_hold`=0, `cmos_sel`=0, `cmos_we`=0, `cmos_addr`=0, `cmos_wdata`=0, `busy`=0. FSM=IDLE.
- Reset mid-transfer releases the CPU and the RAM port asynchronously. No partial write is issued.
- Read latency: `ioctl_rd` at cycle N (in READY):
  - `cmos_addr` valid at N+1.
  - `ioctl_din` valid and `ioctl_wait` low at N+3.
  - `ioctl_wait` is high during N+1 and N+2.
- Write latency: `ioctl_wr` at N:
  - `cmos_we` high for exactly cycle N+1, with addr/data stable.
  - `ioctl_wait` low at N+2.
- HOLD entry: `cpu_hold` is high one cycle after session start. `cmos_sel` is high one cycle after the ack (or timeout).
- `cmos_we` is never high while `cmos_sel` is low.

## Structure
- Package `nvram_pkg`:
  - State enum `nvram_state_t`.
  - Constants `NVRAM_INDEX_DEF`, `CMOS_FILL_NIBBLE` (4'hF), `OOR_BYTE` (8'hFF).
- Single module. The pending-strobe latch and the timeout counter are inline; no sub-module is natural.

## Test plan
- Upload, ack after 3 cycles; RAM[0x005]=4'hA; `ioctl_rd` addr 5 → `ioctl_din`=8'hFA three cycles after the strobe. `ioctl_wait` pulse is 2 cycles.
- Download; `ioctl_wr` addr 0x3FF, `dout`=8'h37 → single `cmos_we`, `cmos_addr`=0x3FF, `cmos_wdata`=4'h7. Read back gives 8'hF7.
- Out-of-range: `ioctl_rd` addr 0x400 → 8'hFF. `ioctl_wr` addr 0x400 → no `cmos_we`.
- No ack: `cpu_hold` high; `cmos_sel` rises after exactly 64 cycles. A strobe latched during HOLD completes after that.
- `reset_n` low during WR → `cmos_we`, `cmos_sel`, `cpu_hold` low immediately. After release, FSM is in IDLE.
- Session end → `cmos_sel` falls, `cpu_hold` falls the next cycle, `busy`=0 the cycle after. Wrong `ioctl_index`=0 produces no activity.
